// File: rtl/mul4_pkg.sv
// Shared types and constants for the mul4 candidate scoring harness.
package mul4_pkg;

    typedef logic [15:0] word_t;
    typedef logic [63:0] dword_t;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        CAPTURE,
        MULT,
        COMPARE,
        DONE
    } state_e;

    // Taps 63, 62, 60, 59 of the left-shifting Fibonacci LFSR
    localparam dword_t LFSR_TAPS  = 64'hD800_0000_0000_0000;
    localparam int     MULT_STEPS = 32;

    function automatic dword_t lfsr_step(input dword_t s);
        return {s[62:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mul4_seq_mult.sv
// 32x32 -> 64 radix-2 shift-add multiplier; one multiplier bit per cycle.
module mul4_seq_mult
    import mul4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid,
    output dword_t      prod
);

    logic        busy;
    logic [5:0]  cnt;
    dword_t      mcand;
    logic [31:0] mplier;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'(MULT_STEPS - 1))
                busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            prod   <= '0;
            mcand  <= {32'd0, a};
            mplier <= b;
        end else if (busy) begin
            if (mplier[0])
                prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // High during the final step; prod is complete on the following cycle
    assign valid = busy && (cnt == 6'(MULT_STEPS - 1));

endmodule

// File: rtl/mul4_vec_scorer.sv
// Fitness harness: drives a mul4 candidate from an LFSR and counts result bits matching a golden product.
// Optional MUL4_SCORER_SIGNED_EN scores against the signed 32x32 product instead of the unsigned one.
module mul4_vec_scorer
    import mul4_pkg::*;
#(
    parameter int          N_VECTORS = 64,
    parameter logic [63:0] LFSR_SEED = 64'h0123_4567_89AB_CDEF,
    parameter int          SCORE_W   = $clog2(N_VECTORS*64+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] score,
    output logic [15:0]        a1,
    output logic [15:0]        a0,
    output logic [15:0]        b1,
    output logic [15:0]        b0,
    input  logic [15:0]        y3,
    input  logic [15:0]        y2,
    input  logic [15:0]        y1,
    input  logic [15:0]        y0
);

    localparam int     VC_W     = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1;
    localparam dword_t SEED_EFF = (LFSR_SEED == 64'd0) ? 64'd1 : LFSR_SEED;

    state_e          state, state_nxt;
    dword_t          lfsr, cand, prod, golden;
    logic [VC_W-1:0] vec_cnt;
    logic            last_vec, mult_load, mult_valid;
    logic [31:0]     mul_a, mul_b;

    function automatic logic [6:0] popcount64(input dword_t v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++)
            c = c + {6'd0, v[i]};
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = MULT;
            MULT:    if (mult_valid) state_nxt = COMPARE;
            COMPARE: state_nxt = last_vec ? DONE : DRIVE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign last_vec  = (vec_cnt == VC_W'(N_VECTORS - 1));
    assign mult_load = (state == CAPTURE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr             <= SEED_EFF;
            vec_cnt          <= '0;
            score            <= '0;
            {a1, a0, b1, b0} <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    lfsr    <= SEED_EFF;
                    vec_cnt <= '0;
                    score   <= '0;
                end
                DRIVE:   {a1, a0, b1, b0} <= lfsr;
                COMPARE: begin
                    score   <= score + SCORE_W'(popcount64(~(cand ^ golden)));
                    lfsr    <= lfsr_step(lfsr);
                    vec_cnt <= vec_cnt + VC_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Operands were registered a full cycle earlier, so the candidate has settled
    always_ff @(posedge clk) begin
        if (state == CAPTURE)
            cand <= {y3, y2, y1, y0};
    end

`ifdef MUL4_SCORER_SIGNED_EN
    logic signed [31:0] op_a, op_b;
    logic               neg;

    assign op_a   = {a1, a0};
    assign op_b   = {b1, b0};
    assign mul_a  = op_a[31] ? $unsigned(-op_a) : $unsigned(op_a);
    assign mul_b  = op_b[31] ? $unsigned(-op_b) : $unsigned(op_b);
    // Operands hold steady through COMPARE, so the sign can be taken live
    assign neg    = op_a[31] ^ op_b[31];
    assign golden = neg ? -prod : prod;
`else
    assign mul_a  = {a1, a0};
    assign mul_b  = {b1, b0};
    assign golden = prod;
`endif

    mul4_seq_mult u_mult (
        .clk   (clk),
        .rst   (rst),
        .load  (mult_load),
        .a     (mul_a),
        .b     (mul_b),
        .valid (mult_valid),
        .prod  (prod)
    );

endmodule

// File: tb/tb_mul4_vec_scorer.sv
// Directed bench for mul4_vec_scorer: four instances with different seeds and vector counts.
module tb_mul4_vec_scorer;

    localparam logic [63:0] SEED_DEF = 64'h0123_4567_89AB_CDEF;
`ifdef MUL4_SCORER_SIGNED_EN
    localparam logic [63:0] P_EXP = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] P_ALT = 64'h0000_0001_FFFF_FFFE;
`else
    localparam logic [63:0] P_EXP = 64'h0000_0001_FFFF_FFFE;
    localparam logic [63:0] P_ALT = 64'hFFFF_FFFF_FFFF_FFFE;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        st [4];
    logic        bz [4];
    logic        dn [4];
    logic [8:0]  sc [4];
    logic [15:0] oa1 [4], oa0 [4], ob1 [4], ob0 [4];
    logic [15:0] iy3 [4], iy2 [4], iy1 [4], iy0 [4];
    logic [6:0]  sc1, sc2, sc3;
    int          md [4];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    // Candidate modes: 0 ideal, 1 ones' complement, 2 zero, 3 expected const, 4 wrong-sign const
    function automatic logic [63:0] cand_fn(input int mode, input logic [15:0] a1, a0, b1, b0);
        logic [63:0] p;
`ifdef MUL4_SCORER_SIGNED_EN
        logic signed [63:0] sa, sb;
        sa = $signed({a1, a0});
        sb = $signed({b1, b0});
        p  = sa * sb;
`else
        p = {32'd0, a1, a0} * {32'd0, b1, b0};
`endif
        case (mode)
            0:       return p;
            1:       return ~p;
            3:       return P_EXP;
            4:       return P_ALT;
            default: return 64'd0;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_cand
        assign {iy3[g], iy2[g], iy1[g], iy0[g]} = cand_fn(md[g], oa1[g], oa0[g], ob1[g], ob0[g]);
    end

    assign sc[1] = {2'b00, sc1};
    assign sc[2] = {2'b00, sc2};
    assign sc[3] = {2'b00, sc3};

    mul4_vec_scorer #(.N_VECTORS(4), .LFSR_SEED(SEED_DEF)) u_n4 (
        .clk(clk), .rst(rst), .start(st[0]), .busy(bz[0]), .done(dn[0]), .score(sc[0]),
        .a1(oa1[0]), .a0(oa0[0]), .b1(ob1[0]), .b0(ob0[0]),
        .y3(iy3[0]), .y2(iy2[0]), .y1(iy1[0]), .y0(iy0[0]));

    mul4_vec_scorer #(.N_VECTORS(1), .LFSR_SEED(64'h0000_0003_0000_0005)) u_35 (
        .clk(clk), .rst(rst), .start(st[1]), .busy(bz[1]), .done(dn[1]), .score(sc1),
        .a1(oa1[1]), .a0(oa0[1]), .b1(ob1[1]), .b0(ob0[1]),
        .y3(iy3[1]), .y2(iy2[1]), .y1(iy1[1]), .y0(iy0[1]));

    mul4_vec_scorer #(.N_VECTORS(1), .LFSR_SEED(64'h0)) u_z (
        .clk(clk), .rst(rst), .start(st[2]), .busy(bz[2]), .done(dn[2]), .score(sc2),
        .a1(oa1[2]), .a0(oa0[2]), .b1(ob1[2]), .b0(ob0[2]),
        .y3(iy3[2]), .y2(iy2[2]), .y1(iy1[2]), .y0(iy0[2]));

    mul4_vec_scorer #(.N_VECTORS(1), .LFSR_SEED(64'hFFFF_FFFF_0000_0002)) u_s (
        .clk(clk), .rst(rst), .start(st[3]), .busy(bz[3]), .done(dn[3]), .score(sc3),
        .a1(oa1[3]), .a0(oa0[3]), .b1(ob1[3]), .b0(ob0[3]),
        .y3(iy3[3]), .y2(iy2[3]), .y1(iy1[3]), .y0(iy0[3]));

    // Pulses start during cycle 0; returns in cycle 1
    task automatic start_run(input int i);
        @(negedge clk) st[i] = 1'b1;
        @(negedge clk) st[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int cyc0, output int cyc);
        cyc = cyc0;
        while (dn[i] !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bz[i] !== 1'b0 || dn[i] !== 1'b0 || sc[i] !== 9'd0) begin
                fails++;
                $display("FAIL reset_ctrl[%0d]: busy=%b done=%b score=%0d, required 0 0 0", i, bz[i], dn[i], sc[i]);
            end
            tests++;
            if ({oa1[i], oa0[i], ob1[i], ob0[i]} !== 64'd0) begin
                fails++;
                $display("FAIL reset_ops[%0d]: got %h required 0", i, {oa1[i], oa0[i], ob1[i], ob0[i]});
            end
        end
    endtask

    task automatic test_ideal();
        int cyc;
        md[0] = 0;
        start_run(0);
        tests++;
        if (bz[0] !== 1'b1) begin
            fails++;
            $display("FAIL ideal_busy_c1: got %b required 1", bz[0]);
        end
        @(negedge clk);
        tests++;
        if ({oa1[0], oa0[0], ob1[0], ob0[0]} !== SEED_DEF) begin
            fails++;
            $display("FAIL ideal_first_vec: got %h required %h", {oa1[0], oa0[0], ob1[0], ob0[0]}, SEED_DEF);
        end
        wait_done(0, 2, cyc);
        tests++;
        if (cyc != 141) begin
            fails++;
            $display("FAIL ideal_done_cycle: got %0d required 141", cyc);
        end
        tests++;
        if (sc[0] !== 9'd256) begin
            fails++;
            $display("FAIL ideal_score: got %0d required 256", sc[0]);
        end
        @(negedge clk);
        tests++;
        if (dn[0] !== 1'b0 || bz[0] !== 1'b0 || sc[0] !== 9'd256) begin
            fails++;
            $display("FAIL ideal_after_done: done=%b busy=%b score=%0d required 0 0 256", dn[0], bz[0], sc[0]);
        end
    endtask

    task automatic test_complement();
        int cyc;
        md[0] = 1;
        start_run(0);
        tests++;
        if (sc[0] !== 9'd0) begin
            fails++;
            $display("FAIL compl_score_cleared: got %0d required 0", sc[0]);
        end
        wait_done(0, 1, cyc);
        tests++;
        if (cyc != 141 || sc[0] !== 9'd0) begin
            fails++;
            $display("FAIL compl_score: cycle %0d score %0d required 141 0", cyc, sc[0]);
        end
        md[0] = 0;
    endtask

    task automatic test_zero_cand();
        int cyc;
        md[1] = 2;
        start_run(1);
        @(negedge clk);
        tests++;
        if ({oa1[1], oa0[1], ob1[1], ob0[1]} !== 64'h0000_0003_0000_0005) begin
            fails++;
            $display("FAIL zero_vec: got %h required 0000000300000005", {oa1[1], oa0[1], ob1[1], ob0[1]});
        end
        wait_done(1, 2, cyc);
        tests++;
        if (cyc != 36 || sc[1] !== 9'd60) begin
            fails++;
            $display("FAIL zero_score: cycle %0d score %0d required 36 60", cyc, sc[1]);
        end
    endtask

    task automatic test_zero_seed();
        int cyc;
        md[2] = 0;
        start_run(2);
        @(negedge clk);
        tests++;
        if ({oa1[2], oa0[2], ob1[2], ob0[2]} !== 64'h1) begin
            fails++;
            $display("FAIL seed0_vec: got %h required 1", {oa1[2], oa0[2], ob1[2], ob0[2]});
        end
        wait_done(2, 2, cyc);
        tests++;
        if (cyc != 36 || sc[2] !== 9'd64) begin
            fails++;
            $display("FAIL seed0_score: cycle %0d score %0d required 36 64", cyc, sc[2]);
        end
    endtask

    task automatic test_restart_ignored();
        int cyc;
        md[0] = 0;
        start_run(0);
        for (int c = 2; c <= 10; c++) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0, 11, cyc);
        tests++;
        if (cyc != 141 || sc[0] !== 9'd256) begin
            fails++;
            $display("FAIL restart_ignored: cycle %0d score %0d required 141 256", cyc, sc[0]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        md[0] = 0;
        start_run(0);
        for (int c = 2; c <= 80; c++) @(negedge clk);
        tests++;
        if (sc[0] !== 9'd128 || bz[0] !== 1'b1) begin
            fails++;
            $display("FAIL midrun_partial: score %0d busy %b required 128 1", sc[0], bz[0]);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (bz[0] !== 1'b0 || sc[0] !== 9'd0 || {oa1[0], oa0[0], ob1[0], ob0[0]} !== 64'd0) begin
            fails++;
            $display("FAIL midrun_reset: busy %b score %0d ops %h required 0 0 0", bz[0], sc[0],
                     {oa1[0], oa0[0], ob1[0], ob0[0]});
        end
        @(negedge clk) rst = 1'b0;
        start_run(0);
        wait_done(0, 1, cyc);
        tests++;
        if (cyc != 141 || sc[0] !== 9'd256) begin
            fails++;
            $display("FAIL midrun_rerun: cycle %0d score %0d required 141 256", cyc, sc[0]);
        end
    endtask

    task automatic test_signed();
        int cyc;
        int exp_sc [3] = '{64, 64, 33};
        int modes  [3] = '{3, 0, 4};
        for (int k = 0; k < 3; k++) begin
            md[3] = modes[k];
            start_run(3);
            @(negedge clk);
            if (k == 0) begin
                tests++;
                if ({oa1[3], oa0[3], ob1[3], ob0[3]} !== 64'hFFFF_FFFF_0000_0002) begin
                    fails++;
                    $display("FAIL sign_vec: got %h required ffffffff00000002", {oa1[3], oa0[3], ob1[3], ob0[3]});
                end
            end
            wait_done(3, 2, cyc);
            tests++;
            if (cyc != 36 || sc[3] !== 9'(exp_sc[k])) begin
                fails++;
                $display("FAIL sign_score[mode %0d]: cycle %0d score %0d required 36 %0d", modes[k], cyc, sc[3], exp_sc[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st[i] = 1'b0;
            md[i] = 0;
        end
        md[1] = 2;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_ideal();
        test_complement();
        test_zero_cand();
        test_zero_seed();
        test_restart_ignored();
        test_reset_mid();
        test_signed();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
